// File: rtl/apb_mem_slave.sv
// APB memory slave: a DEPTH x DATA_W word-addressed memory behind an APB
// completer with byte strobes, programmable wait states, error response for
// out-of-range word indices and abort handling when psel drops mid-transfer.
// Memory contents reset to their own index so reads are predictable after reset.
module apb_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                capture_s;
  logic                cnt_dec_s;
  logic                complete_s;
  logic [ADDR_W-1:0]   addr_r;
  logic                write_r;
  logic [DATA_W-1:0]   data_r;
  logic [STRB_W-1:0]   strb_r;
  logic [3:0]          cnt_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic                err_s;
  logic [IDX_W-1:0]    idx_s;
  logic                wr_en_s;
  logic [DATA_W-1:0]   prdata_s;

  // Merge new write data into an existing word, one byte lane per strobe bit.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] result;
    result = old_word;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) begin
        result[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        result[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return result;
  endfunction

  // Range check on the full captured address before any truncation, so an
  // out-of-range index can never alias onto a valid word.
  assign err_s = (64'(addr_r) >= 64'(DEPTH));
  assign idx_s = addr_r[IDX_W-1:0];

  // Reset overrides everything, including a completion that would land on the reset edge.
  assign pready  = complete_s & ~rst;
  assign pslverr = pready & err_s;
  assign wr_en_s = pready & write_r & ~err_s & (|strb_r);
  assign prdata  = prdata_s;

  // Next-state logic and per-cycle control strobes for the transfer FSM.
  always_comb begin
    state_s    = state_r;
    capture_s  = 1'b0;
    cnt_dec_s  = 1'b0;
    complete_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (psel && !penable) begin
          state_s   = ACCESS;
          capture_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_s = IDLE;
        end else if (penable) begin
          if (cnt_r == 4'd0) begin
            complete_s = 1'b1;
            state_s    = DONE;
          end else begin
            cnt_dec_s = 1'b1;
            state_s   = ACCESS;
          end
        end else begin
          state_s = ACCESS;
        end
      end
      DONE: begin
        if (psel && !penable) begin
          state_s   = ACCESS;
          capture_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Read data is only presented on a clean read completion; zero otherwise.
  always_comb begin
    prdata_s = {DATA_W{1'b0}};
    if (pready && !write_r && !err_s) begin
      prdata_s = mem_r[idx_s];
    end else begin
      prdata_s = {DATA_W{1'b0}};
    end
  end

  // FSM state, setup-phase capture registers and wait-state counter.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r <= IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      write_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
      strb_r  <= {STRB_W{1'b0}};
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      if (capture_s) begin
        addr_r  <= paddr;
        write_r <= pwrite;
        data_r  <= pwdata;
        strb_r  <= pstrb;
        cnt_r   <= WAIT_INIT;
      end else if (cnt_dec_s) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Memory array: initialised to its own index on reset, strobed writes on completion.
  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= DATA_W'(i);
      end
    end else if (wr_en_s) begin
      mem_r[idx_s] <= merge_bytes(mem_r[idx_s], data_r, strb_r);
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed testbench for apb_mem_slave. Three instances differ only in
// WAIT_CYCLES (0, 3, 2) and share clock and reset.
module tb_apb_mem_slave;

  logic        pclk = 1'b0;
  logic        rst;
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic [3:0]  pstrb   [3];
  logic        pready  [3];
  logic [31:0] prdata  [3];
  logic        pslverr [3];

  int ntests = 0;
  int nfail  = 0;

  always #5 pclk = ~pclk;

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .rst(rst), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
    .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]));

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(3)) dut1 (
    .pclk(pclk), .rst(rst), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
    .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]));

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(2)) dut2 (
    .pclk(pclk), .rst(rst), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
    .paddr(paddr[2]), .pwdata(pwdata[2]), .pstrb(pstrb[2]),
    .pready(pready[2]), .prdata(prdata[2]), .pslverr(pslverr[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full transfer starting just after a rising edge; returns just after the
  // completing edge with psel still high so a setup can follow immediately.
  // Bus inputs are scrambled during ACCESS to prove only setup values count.
  task automatic xfer(input int d, input string tag, input logic wr,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int waits,
                      output logic [31:0] rdata, output logic err);
    int cyc;
    bit done;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = data; pstrb[d] = strb;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    pwrite[d] = ~wr; paddr[d] = ~addr; pwdata[d] = ~data; pstrb[d] = ~strb;
    cyc = 0; done = 1'b0; rdata = 32'd0; err = 1'b0;
    while (!done && cyc <= 20) begin
      @(negedge pclk);
      if (pready[d] === 1'b1) begin
        rdata = prdata[d];
        err   = pslverr[d];
        done  = 1'b1;
      end else begin
        check({tag, "_prdata_while_wait"}, prdata[d], 32'd0);
        check({tag, "_pslverr_while_wait"}, {31'd0, pslverr[d]}, 32'd0);
        cyc++;
      end
      @(posedge pclk); #1;
    end
    check({tag, "_wait_cycles"}, 32'(cyc), 32'(waits));
  endtask

  task automatic idle(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0;
    @(posedge pclk); #1;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = 32'd0; pwdata[i] = 32'd0; pstrb[i] = 4'd0;
    end
    repeat (3) @(posedge pclk);
    #1 rst = 1'b0;

    // Reset state of outputs
    @(negedge pclk);
    check("rst_pready", {31'd0, pready[0]}, 32'd0);
    check("rst_pslverr", {31'd0, pslverr[0]}, 32'd0);
    check("rst_prdata", prdata[0], 32'd0);
    @(posedge pclk); #1;

    // Default read of reset contents
    xfer(0, "rd5", 1'b0, 32'd5, 32'd0, 4'h0, 0, rd, er);
    check("rd5_data", rd, 32'h0000_0005);
    check("rd5_err", {31'd0, er}, 32'd0);
    idle(0);

    // Strobed write then read-back
    xfer(0, "wr3", 1'b1, 32'd3, 32'hAABB_CCDD, 4'b0101, 0, rd, er);
    check("wr3_err", {31'd0, er}, 32'd0);
    idle(0);
    xfer(0, "rd3", 1'b0, 32'd3, 32'd0, 4'h0, 0, rd, er);
    check("rd3_data", rd, 32'h00BB_00DD);
    idle(0);

    // Three wait states
    xfer(1, "rd7w3", 1'b0, 32'd7, 32'd0, 4'h0, 3, rd, er);
    check("rd7w3_data", rd, 32'h0000_0007);
    check("rd7w3_err", {31'd0, er}, 32'd0);
    idle(1);

    // Out-of-range write, no alias onto word 0
    xfer(0, "wr256", 1'b1, 32'd256, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    check("wr256_err", {31'd0, er}, 32'd1);
    idle(0);
    xfer(0, "rd0", 1'b0, 32'd0, 32'd0, 4'h0, 0, rd, er);
    check("rd0_data", rd, 32'h0000_0000);
    check("rd0_err", {31'd0, er}, 32'd0);
    idle(0);
    xfer(0, "rd256", 1'b0, 32'd256, 32'd0, 4'h0, 0, rd, er);
    check("rd256_data", rd, 32'h0000_0000);
    check("rd256_err", {31'd0, er}, 32'd1);
    idle(0);

    // Zero-strobe write leaves memory unchanged
    xfer(0, "wr4s0", 1'b1, 32'd4, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
    idle(0);
    xfer(0, "rd4", 1'b0, 32'd4, 32'd0, 4'h0, 0, rd, er);
    check("rd4_data", rd, 32'h0000_0004);
    idle(0);

    // penable without setup in IDLE is ignored
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 32'd6; pwdata[0] = 32'h1111_1111; pstrb[0] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("noset_pready", {31'd0, pready[0]}, 32'd0);
      @(posedge pclk); #1;
    end
    idle(0);
    xfer(0, "rd6", 1'b0, 32'd6, 32'd0, 4'h0, 0, rd, er);
    check("rd6_data", rd, 32'h0000_0006);
    idle(0);

    // Abort of a write to addr 9 with two wait states
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 32'd9; pwdata[2] = 32'hDEAD_BEEF; pstrb[2] = 4'hF;
    @(posedge pclk); #1;
    penable[2] = 1'b1;
    @(negedge pclk);
    check("abort_pready_acc", {31'd0, pready[2]}, 32'd0);
    @(posedge pclk); #1;
    psel[2] = 1'b0; penable[2] = 1'b0;
    @(negedge pclk);
    check("abort_pready", {31'd0, pready[2]}, 32'd0);
    check("abort_pslverr", {31'd0, pslverr[2]}, 32'd0);
    @(posedge pclk); #1;
    xfer(2, "rd9", 1'b0, 32'd9, 32'd0, 4'h0, 2, rd, er);
    check("rd9_data", rd, 32'h0000_0009);
    idle(2);

    // Back-to-back write then read on addr 1
    xfer(0, "b2b_wr1", 1'b1, 32'd1, 32'h1234_5678, 4'hF, 0, rd, er);
    xfer(0, "b2b_rd1", 1'b0, 32'd1, 32'd0, 4'h0, 0, rd, er);
    check("b2b_rd1_data", rd, 32'h1234_5678);
    idle(0);

    // Reset during ACCESS on the three-wait-state instance
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'd2; pwdata[1] = 32'hFFFF_FFFF; pstrb[1] = 4'hF;
    @(posedge pclk); #1;
    penable[1] = 1'b1;
    @(negedge pclk);
    check("rstacc_pready_before", {31'd0, pready[1]}, 32'd0);
    @(posedge pclk); #1;
    rst = 1'b1;
    @(posedge pclk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      check("rstacc_pready_after", {31'd0, pready[1]}, 32'd0);
      check("rstacc_prdata_after", prdata[1], 32'd0);
      @(posedge pclk); #1;
    end
    idle(1);
    xfer(1, "rd2", 1'b0, 32'd2, 32'd0, 4'h0, 3, rd, er);
    check("rd2_data", rd, 32'h0000_0002);
    idle(1);
    xfer(0, "rd3_after_rst", 1'b0, 32'd3, 32'd0, 4'h0, 0, rd, er);
    check("rd3_after_rst_data", rd, 32'h0000_0003);
    idle(0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: data bus width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 32: width of paddr.
REQ-003 The block SHALL have parameter DEPTH, default 256: number of DATA_W-bit memory words.
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 0, range 0..15: wait states inserted in every access phase.
REQ-005 The block SHALL have port pclk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port psel, input, 1 bit: slave select.
REQ-008 The block SHALL have port penable, input, 1 bit: access-phase indicator.
REQ-009 The block SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port paddr, input, ADDR_W bits: word index, not a byte address.
REQ-011 The block SHALL have port pwdata, input, DATA_W bits: write data.
REQ-012 The block SHALL have port pstrb, input, DATA_W/8 bits: byte write strobes.
REQ-013 The block SHALL have port pready, output, 1 bit: transfer completes this cycle.
REQ-014 The block SHALL have port prdata, output, DATA_W bits: read data.
REQ-015 The block SHALL have port pslverr, output, 1 bit: error response, valid only while pready=1.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-017 In IDLE, when psel=1 and penable=0 (setup), the FSM SHALL go to ACCESS, capture paddr, pwrite, pwdata and pstrb into registers, and load wait counter cnt with WAIT_CYCLES.
REQ-018 In ACCESS, while psel=1, penable=1 and cnt>0, the FSM SHALL hold pready=0 and decrement cnt by 1 per cycle.
REQ-019 In ACCESS, when psel=1, penable=1 and cnt=0, the block SHALL drive pready=1 combinationally from registered state, completing the transfer at that rising edge and going to DONE.
REQ-020 Access latency SHALL be one setup cycle plus WAIT_CYCLES+1 access cycles; WAIT_CYCLES=0 gives the standard two-cycle transfer.
REQ-021 An error SHALL be flagged when the captured address >= DEPTH; pslverr SHALL equal that error flag whenever pready=1, and SHALL be 0 otherwise.
REQ-022 On a write completion with no error, each byte lane k with pstrb[k]=1 SHALL be updated from the captured pwdata; lanes with pstrb[k]=0 SHALL keep their value.
REQ-023 On a write with an error, or with pstrb all zero, memory SHALL NOT change.
REQ-024 On a read completion, prdata SHALL be mem[captured address] when there is no error, and 0 on error.
REQ-025 prdata SHALL be 0 in every cycle where pready=0.
REQ-026 Paddr/pwdata/pstrb changes during ACCESS SHALL be ignored; only the values captured at setup are used.
REQ-027 From DONE, the FSM SHALL return to IDLE next cycle; if that cycle is a setup (psel=1, penable=0), it SHALL go directly to ACCESS, so back-to-back transfers incur no idle cycle.
REQ-028 Abort: if psel=0 in ACCESS before completion, the FSM SHALL go to IDLE, perform no write, and assert neither pready nor pslverr.
REQ-029 In IDLE, penable=1 without a preceding setup SHALL be ignored (no state change, pready=0).
REQ-030 Memory index arithmetic SHALL use clog2(DEPTH) low bits only after the range check; an out-of-range address SHALL never alias onto a valid word.

Reset
REQ-031 While rst=1 at a rising edge, the FSM SHALL go to IDLE, cnt and all captured registers SHALL clear to 0, and pready, pslverr and prdata SHALL be 0 from the next cycle.
REQ-032 Reset SHALL initialise mem[i] to i (truncated to DATA_W) for 0 <= i < DEPTH.
REQ-033 Reset asserted mid-transfer SHALL abort that transfer with no write committed; rst SHALL take priority over all other inputs.

Verification
REQ-034 Bench SHALL cover default-reset read: after reset, read addr 5 with WAIT_CYCLES=0 -> pready=1 on the 2nd cycle, prdata=0x00000005, pslverr=0.
REQ-035 Bench SHALL cover strobed write: write addr 3, pwdata=0xAABBCCDD, pstrb=4'b0101, then read addr 3 -> prdata=0x00BB00DD.
REQ-036 Bench SHALL cover wait states: WAIT_CYCLES=3, read addr 7 -> pready=0 for the first 3 access cycles, pready=1 on the 4th with prdata=0x7.
REQ-037 Bench SHALL cover out-of-range access: write to addr 256 (DEPTH=256) -> pready=1, pslverr=1; a subsequent read of addr 0 returns 0x0, proving no alias.
REQ-038 Bench SHALL cover abort: psel drops in ACCESS during a write (WAIT_CYCLES=2) to addr 9 -> no pready, mem[9] still 9.
REQ-039 Bench SHALL cover back-to-back and reset: back-to-back write then read on addr 1 with no idle cycle -> read returns the written data; rst=1 during ACCESS -> pready=0 next cycle, FSM in IDLE.
